// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, queue entry layout and defaults for the fetch front end
package fetch_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  localparam logic [4:0] HALT_OP_DEF = 5'b0;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, HALTED} fetch_state_t;
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [DATA_W_DEF-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry FIFO with synchronous flush and occupancy count
module fetch_queue #(
  parameter int W = 32,
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          valid,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk)
    if (push && !flush) mem[wp] <= din;
  assign dout = mem[rp];
  assign valid = count != '0;
endmodule

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: sequential PC generator, single-outstanding imem reader and prefetch queue to decode.
// Define FETCH_PERF_EN to add the perf_fetched / perf_stall saturating counters.
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH = 4,
  parameter int PC_INC = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [4:0] HALT_OP = HALT_OP_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_done,
  input  logic              mem_stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_next,
  output logic              halt
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int QW = ADDR_W + DATA_W;
  fetch_state_t state, state_nx;
  logic [ADDR_W-1:0] fetch_pc;
  logic [CW-1:0] count;
  logic [QW-1:0] head;
  logic push, pop, in_flight;
  assign push = state == WAIT && mem_done && !redirect;
  assign pop = if_valid && if_ready && !redirect;
  fetch_queue #(.W(QW), .DEPTH(DEPTH)) u_queue (
    .clk(clk), .rst_n(rst_n), .flush(redirect), .push(push), .pop(pop),
    .din({fetch_pc, mem_data}), .dout(head), .valid(if_valid), .count(count)
  );
  // A redirect leaves a read in flight if it was already accepted and its data has not returned yet
  assign in_flight = ((state == WAIT || state == DRAIN) && !mem_done) || (state == REQ && !mem_stall);
  always_comb begin
    state_nx = state;
    if (redirect) state_nx = in_flight ? DRAIN : IDLE;
    else
      case (state)
        IDLE:    state_nx = count < CW'(DEPTH) ? REQ : IDLE;
        REQ:     state_nx = mem_stall ? REQ : WAIT;
        WAIT:    state_nx = !mem_done ? WAIT :
                            mem_data[DATA_W-1 -: 5] == HALT_OP ? HALTED :
                            count < CW'(DEPTH - 1) ? REQ : IDLE;
        DRAIN:   state_nx = mem_done ? IDLE : DRAIN;
        default: state_nx = HALTED;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state <= state_nx;
      if (redirect) fetch_pc <= redirect_pc;
      else if (push) fetch_pc <= fetch_pc + ADDR_W'(PC_INC);
    end
  end
  assign mem_rd = state == REQ;
  assign mem_addr = mem_rd ? fetch_pc : '0;
  assign if_pc = if_valid ? head[QW-1 -: ADDR_W] : '0;
  assign if_instr = if_valid ? head[DATA_W-1:0] : '0;
  assign if_pc_next = if_valid ? if_pc + ADDR_W'(PC_INC) : '0;
  assign halt = if_valid && if_instr[DATA_W-1 -: 5] == HALT_OP;
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall <= '0;
    end else begin
      if (push && ~&perf_fetched) perf_fetched <= perf_fetched + 32'd1;
      if ((state == REQ || state == WAIT) && count == '0 && ~&perf_stall) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: scoreboard of expected (pc, instr) pairs checked at each decode handshake,
// a redirect vector table, and hand-written backpressure / halt / stall / drain / async-reset sequences.
module tb_fetch_prefetch_queue;
  logic clk = 0, rst_n = 0;
  logic mem_rd, mem_done = 0, mem_stall = 0, redirect = 0, if_valid, if_ready = 0, halt;
  logic [15:0] mem_addr, mem_data = '0, redirect_pc = '0, if_instr, if_pc, if_pc_next;

  fetch_prefetch_queue dut (
    .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_done(mem_done), .mem_stall(mem_stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .if_pc_next(if_pc_next), .halt(halt)
  );

  always #5 clk = ~clk;

  typedef struct {logic [15:0] pc; logic [15:0] instr;} exp_t;
  typedef struct {logic [15:0] target; int n; logic [15:0] last_next;} vec_t;

  exp_t sb[$];
  exp_t me;
  int pop_cyc[$];
  int n_pass = 0, n_total = 0, cyc = 0, nreads = 0, lat = 0;
  logic [15:0] halt_pc = 16'hFFFF, last_next = '0, ma;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return (a == halt_pc) ? 16'h0000 : (16'hA000 ^ a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // instruction memory: accepts at most one read, returns data lat+1 cycles later as a one-cycle pulse
  always begin
    @(negedge clk);
    if (mem_rd && !mem_stall) begin
      ma = mem_addr;
      nreads++;
      repeat (lat) @(negedge clk);
      @(posedge clk); #1;
      mem_done = 1;
      mem_data = mem_fn(ma);
      @(posedge clk); #1;
      mem_done = 0;
    end
  end

  always @(negedge clk)
    if (rst_n && !redirect && if_valid && if_ready) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_pop: got pc %h expected no instruction", if_pc);
      end else begin
        me = sb.pop_front();
        chk("if_pc", 32'(if_pc), 32'(me.pc));
        chk("if_instr", 32'(if_instr), 32'(me.instr));
        chk("if_pc_next", 32'(if_pc_next), 32'(16'(me.pc + 16'd2)));
        last_next = if_pc_next;
        pop_cyc.push_back(cyc);
      end
    end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic expect_run(input logic [15:0] pc, input int n);
    for (int k = 0; k < n; k++) begin
      sb.push_back('{pc, mem_fn(pc)});
      pc = pc + 16'd2;
    end
  endtask

  task automatic drain();
    int t = 0;
    if_ready = 1;
    while (sb.size() > 0 && t < 200) begin step(); t++; end
    if_ready = 0;
    chk("drain_left", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic do_redirect(input logic [15:0] pc);
    redirect = 1;
    redirect_pc = pc;
    step();
    redirect = 0;
    chk("valid_after_redirect", 32'(if_valid), 32'd0);
  endtask

  task automatic wait_rd(input string nm);
    int t = 0;
    while (!mem_rd && t < 50) begin step(); t++; end
    chk(nm, 32'(mem_rd), 32'd1);
  endtask

  task automatic wait_valid(input string nm);
    int t = 0;
    while (!if_valid && t < 50) begin step(); t++; end
    chk(nm, 32'(if_valid), 32'd1);
  endtask

  initial begin #200000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

  initial begin
    vec_t vecs[4];
    int n0;
    vecs[0] = '{16'h0100, 3, 16'h0106};
    vecs[1] = '{16'hFFFE, 3, 16'h0004};
    vecs[2] = '{16'h0020, 2, 16'h0024};
    vecs[3] = '{16'h0A00, 2, 16'h0A04};
    repeat (2) step();
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_halt", 32'(halt), 32'd0);
    chk("rst_if_pc_next", 32'(if_pc_next), 32'd0);
    rst_n = 1;
    // straight-line fetch from RESET_PC, one instruction every two cycles
    expect_run(16'h0000, 4);
    pop_cyc.delete();
    drain();
    chk("throughput", 32'(pop_cyc[3] - pop_cyc[0]), 32'd6);
    // backpressure: the queue fills with exactly DEPTH reads and the head holds
    do_redirect(16'h0040);
    n0 = nreads;
    repeat (5) step();
    chk("bp_head_early", 32'(if_pc), 32'h0040);
    repeat (15) step();
    chk("bp_reads", 32'(nreads - n0), 32'd4);
    chk("bp_mem_rd", 32'(mem_rd), 32'd0);
    chk("bp_head_late", 32'(if_pc), 32'h0040);
    chk("bp_head_instr", 32'(if_instr), 32'(mem_fn(16'h0040)));
    expect_run(16'h0040, 5);
    drain();
    // redirect table, including the PC wrap from FFFE
    for (int i = 0; i < 4; i++) begin
      if_ready = 1;
      do_redirect(vecs[i].target);
      expect_run(vecs[i].target, vecs[i].n);
      drain();
      chk("last_pc_next", 32'(last_next), 32'(vecs[i].last_next));
    end
    // redirect while a read is outstanding: its data must be dropped
    lat = 3;
    do_redirect(16'h0200);
    wait_rd("wait_req_0200");
    step();
    chk("in_wait_no_rd", 32'(mem_rd), 32'd0);
    if_ready = 1;
    do_redirect(16'h0100);
    lat = 0;
    expect_run(16'h0100, 2);
    drain();
    // halt opcode at PC 6 stops prefetch until a redirect
    halt_pc = 16'h0006;
    if_ready = 1;
    do_redirect(16'h0000);
    expect_run(16'h0000, 3);
    drain();
    wait_valid("halt_head_valid");
    chk("halt_head_pc", 32'(if_pc), 32'h0006);
    chk("halt_flag", 32'(halt), 32'd1);
    chk("halt_pc_next", 32'(if_pc_next), 32'h0008);
    n0 = nreads;
    repeat (10) step();
    chk("halt_no_reads", 32'(nreads - n0), 32'd0);
    chk("halt_held", 32'(halt), 32'd1);
    if_ready = 1;
    do_redirect(16'h0020);
    chk("halt_cleared", 32'(halt), 32'd0);
    halt_pc = 16'hFFFF;
    expect_run(16'h0020, 2);
    drain();
    // memory stall: request and address held, nothing enqueued
    mem_stall = 1;
    do_redirect(16'h0300);
    wait_rd("stall_req");
    n0 = nreads;
    for (int k = 0; k < 5; k++) begin
      chk("stall_mem_rd", 32'(mem_rd), 32'd1);
      chk("stall_mem_addr", 32'(mem_addr), 32'h0300);
      step();
    end
    chk("stall_no_enq", 32'(if_valid), 32'd0);
    chk("stall_no_reads", 32'(nreads - n0), 32'd0);
    mem_stall = 0;
    expect_run(16'h0300, 2);
    drain();
    // asynchronous reset in the middle of a WAIT with a non-empty queue
    do_redirect(16'h0400);
    wait_valid("ar_valid");
    lat = 3;
    wait_rd("ar_req");
    step();
    #2 rst_n = 0;
    #1;
    chk("ar_mem_rd", 32'(mem_rd), 32'd0);
    chk("ar_mem_addr", 32'(mem_addr), 32'd0);
    chk("ar_if_valid", 32'(if_valid), 32'd0);
    chk("ar_if_pc", 32'(if_pc), 32'd0);
    chk("ar_if_instr", 32'(if_instr), 32'd0);
    chk("ar_halt", 32'(halt), 32'd0);
    mem_stall = 1;
    repeat (3) step();
    rst_n = 1;
    repeat (8) step();
    chk("ar_restart_rd", 32'(mem_rd), 32'd1);
    chk("ar_restart_addr", 32'(mem_addr), 32'h0000);
    lat = 0;
    mem_stall = 0;
    expect_run(16'h0000, 2);
    drain();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
